// File: rtl/exp_taylor_sequencer_if.sv
// Handshake, result and reciprocal-table bundle for the exp(x) Taylor sequencer.
// slave = the sequencer, master = the operand source / result sink / table owner.
interface exp_taylor_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] x;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] y;
  logic [4:0]            lut_adr;
  logic [DATA_WIDTH-1:0] lut_val;

  modport master (
    output in_valid, x, out_ready, lut_val,
    input  in_ready, out_valid, y, lut_adr
  );

  modport slave (
    input  in_valid, x, out_ready, lut_val,
    output in_ready, out_valid, y, lut_adr
  );
endinterface

// File: rtl/exp_taylor_sequencer.sv
// Iterative exp(x) via Taylor series: term *= x, term *= 1/k, sum += term, k = 1..N_TERMS.
// Optional build macro EXP_TAYLOR_EARLY_EXIT_EN stops iterating once the term underflows to 0.
module exp_taylor_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int FRACTION_BITS = 30,
  parameter int N_TERMS       = 18
) (
  input logic                   clk,
  input logic                   rst_n,
  exp_taylor_sequencer_if.slave bus
);
  localparam int PW = 2 * DATA_WIDTH;

  localparam logic signed [DATA_WIDTH-1:0] ONE =
    {{(DATA_WIDTH-FRACTION_BITS-1){1'b0}}, 1'b1, {FRACTION_BITS{1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] MAX_V = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MAX_W = {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_W = {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [4:0] K_LAST = 5'(N_TERMS);

  typedef enum logic [1:0] {IDLE, MUL_X, MUL_INV, DONE} state_t;

  state_t                  state_q, state_d;
  logic signed [DATA_WIDTH-1:0] x_q, x_d;
  logic signed [DATA_WIDTH-1:0] term_q, term_d;
  logic signed [DATA_WIDTH-1:0] sum_q, sum_d;
  logic signed [DATA_WIDTH-1:0] y_q, y_d;
  logic [4:0]              k_q, k_d;
  logic                    satp_q, satp_d;

  logic signed [DATA_WIDTH-1:0] mul_op;
  logic signed [PW-1:0]         prod;
  logic signed [DATA_WIDTH-1:0] term_new;
  logic signed [PW-1:0]         add_w;
  logic                         add_ovf;
  logic signed [DATA_WIDTH-1:0] sum_new;
  logic                         last;

  function automatic logic signed [DATA_WIDTH-1:0] sat_w(input logic signed [PW-1:0] v);
    if (v > MAX_W)      return MAX_V;
    else if (v < MIN_W) return ~MAX_V;
    else                return v[DATA_WIDTH-1:0];
  endfunction

  // One shared multiplier: x in MUL_X, table reciprocal in MUL_INV.
  always_comb begin
    mul_op   = (state_q == MUL_INV) ? $signed(bus.lut_val) : x_q;
    prod     = PW'(term_q) * PW'(mul_op);
    term_new = sat_w(prod >>> FRACTION_BITS);
    add_w    = PW'(sum_q) + PW'(term_new);
    add_ovf  = satp_q || (add_w > MAX_W);
    sum_new  = add_ovf ? MAX_V : sat_w(add_w);
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    term_d  = term_q;
    sum_d   = sum_q;
    y_d     = y_q;
    k_d     = k_q;
    satp_d  = satp_q;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          x_d     = $signed(bus.x);
          term_d  = ONE;
          sum_d   = ONE;
          k_d     = 5'd1;
          satp_d  = 1'b0;
          state_d = MUL_X;
        end
      end
      MUL_X: begin
        term_d  = term_new;
        state_d = MUL_INV;
      end
      MUL_INV: begin
        term_d = term_new;
        sum_d  = sum_new;
        satp_d = add_ovf;
        last   = (k_q == K_LAST);
`ifdef EXP_TAYLOR_EARLY_EXIT_EN
        if (term_new == '0) last = 1'b1;
`endif
        if (last) begin
          y_d     = sum_new[DATA_WIDTH-1] ? '0 : sum_new;
          state_d = DONE;
        end else begin
          k_d     = k_q + 5'd1;
          state_d = MUL_X;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      term_q  <= '0;
      sum_q   <= '0;
      y_q     <= '0;
      k_q     <= '0;
      satp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      term_q  <= term_d;
      sum_q   <= sum_d;
      y_q     <= y_d;
      k_q     <= k_d;
      satp_q  <= satp_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.y         = y_q;
  assign bus.lut_adr   = (state_q == MUL_INV) ? k_q : 5'd0;
endmodule
